// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: banked register file with write-back bypass and issue scoreboard
//   clk, rst      : clock, synchronous active-high reset
//   rd_id/rd_data : NRD source ports, combinational read with same-cycle write bypass
//   wr_en/wr_id/wr_data : write-back port, clears the pending bit of wr_id
//   iss_*         : issue handshake; iss_ready is combinational
//   flush         : clears every pending bit, register data untouched
//   busy_vec      : pending-write bit per register id
//   stall_cnt     : saturating count of stalled issue cycles
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NBANK = 2,
    parameter int NRD   = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h30),
    parameter logic [XLEN-1:0] GP_INIT = XLEN'(32'hF4240),
    localparam int IDW  = $clog2(NBANK) + $clog2(NREG),
    localparam int NTOT = NBANK * NREG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*IDW-1:0]  rd_id,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [IDW-1:0]      wr_id,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_valid,
    input  logic [NRD-1:0]      iss_src_en,
    input  logic                iss_dst_en,
    input  logic [IDW-1:0]      iss_dst_id,
    output logic                iss_ready,
    input  logic                flush,
    output logic [NTOT-1:0]     busy_vec,
    output logic [31:0]         stall_cnt
);
    logic [XLEN-1:0] r_regs [NTOT];
    logic [NTOT-1:0] r_busy;
    logic [31:0]     r_stall;
    logic [NRD-1:0]  w_src_ok;
    logic            w_dst_ok;
    logic [NTOT-1:0] w_set;
    logic [NTOT-1:0] w_clr;
    genvar i;
    generate
        for (i = 0; i < NRD; i++) begin : g_rd
            logic [IDW-1:0] w_id;
            logic           w_byp;
            assign w_id  = rd_id[i*IDW +: IDW];
            assign w_byp = wr_en && wr_id == w_id;
            assign rd_data[i*XLEN +: XLEN] = w_id == '0 ? '0 : w_byp ? wr_data : r_regs[w_id];
            // a write-back landing this cycle resolves the hazard through the bypass
            assign w_src_ok[i] = !iss_src_en[i] || !r_busy[w_id] || w_byp;
        end
    endgenerate
    assign w_dst_ok  = !iss_dst_en || !r_busy[iss_dst_id];
    assign iss_ready = iss_valid && !flush && !rst && (&w_src_ok) && w_dst_ok;
    // id 0 is hardwired zero so it is masked out of the set vector
    assign w_set = (iss_ready && iss_dst_en) ? (NTOT'(1) << iss_dst_id) & ~NTOT'(1) : '0;
    assign w_clr = wr_en ? NTOT'(1) << wr_id : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTOT; k++)
                r_regs[k] <= k == 29 ? SP_INIT : k == 28 ? GP_INIT : '0;
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            if (wr_en && wr_id != '0)
                r_regs[wr_id] <= wr_data;
            r_busy <= flush ? '0 : (r_busy & ~w_clr) | w_set;
            if (iss_valid && !iss_ready && !flush && r_stall != '1)
                r_stall <= r_stall + 32'd1;
        end
    end
    assign busy_vec  = r_busy;
    assign stall_cnt = r_stall;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with a queued scoreboard checked at the falling edge
module tb_regfile_scoreboard;
    localparam int IDW = 6;
    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst;
    logic [11:0] rd_id;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [5:0]  wr_id;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic [1:0]  iss_src_en;
    logic        iss_dst_en;
    logic [5:0]  iss_dst_id;
    logic        iss_ready;
    logic        flush;
    logic [63:0] busy_vec;
    logic [31:0] stall_cnt;

    exp_t        q[$];
    exp_t        e;
    logic [63:0] act;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_id(rd_id), .rd_data(rd_data),
        .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_src_en(iss_src_en), .iss_dst_en(iss_dst_en),
        .iss_dst_id(iss_dst_id), .iss_ready(iss_ready), .flush(flush),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            0: pick = {32'd0, rd_data[31:0]};
            1: pick = {32'd0, rd_data[63:32]};
            2: pick = {63'd0, iss_ready};
            3: pick = busy_vec;
            default: pick = {32'd0, stall_cnt};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = pick(e.sel);
            n_vec++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_err++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc, act, e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [63:0] v, input string name);
        q.push_back('{cyc, sel, v, name});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] se, input logic de, input logic [5:0] did,
                         input logic we, input logic [5:0] wid, input logic [31:0] wd);
        iss_valid = v; iss_src_en = se; iss_dst_en = de; iss_dst_id = did;
        wr_en = we; wr_id = wid; wr_data = wd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rd_id = '0;
        drive(1, 2'b00, 1, 6'd3, 1, 6'd4, 32'h55);
        expect_val(2, 0, "ready_in_reset");
        tick(); rst = 1'b0;
        rd_id = {6'd28, 6'd29};
        drive(0, 2'b00, 0, 6'd0, 0, 6'd0, 0);
        expect_val(0, 64'h30, "sp_init");
        expect_val(1, 64'hF4240, "gp_init");
        expect_val(3, 0, "busy_reset");
        expect_val(4, 0, "stall_reset");
        tick(); drive(1, 2'b00, 1, 6'd5, 0, 6'd0, 0);
        expect_val(2, 1, "issue_r5");
        tick(); rd_id = {6'd28, 6'd5}; drive(1, 2'b01, 0, 6'd0, 0, 6'd0, 0);
        expect_val(3, 64'h20, "busy_r5");
        expect_val(2, 0, "raw_stall");
        tick();
        expect_val(4, 1, "stall_cnt_1");
        expect_val(2, 0, "raw_stall_2");
        tick(); drive(1, 2'b01, 0, 6'd0, 1, 6'd5, 32'hDEAD);
        expect_val(4, 2, "stall_cnt_2");
        expect_val(2, 1, "raw_bypass_ready");
        expect_val(0, 64'hDEAD, "rd_bypass");
        tick(); drive(0, 2'b00, 0, 6'd0, 0, 6'd0, 0);
        expect_val(3, 0, "busy_r5_clear");
        expect_val(4, 2, "stall_hold");
        expect_val(0, 64'hDEAD, "rd_stored");
        tick(); rd_id = {6'd28, 6'd0}; drive(1, 2'b00, 1, 6'd0, 1, 6'd0, 32'hFFFF);
        expect_val(0, 0, "r0_bypass_zero");
        expect_val(2, 1, "issue_r0");
        tick(); drive(0, 2'b00, 0, 6'd0, 0, 6'd0, 0);
        expect_val(0, 0, "r0_zero");
        expect_val(3, 0, "r0_never_busy");
        tick(); rd_id = {6'd33, 6'd0}; drive(1, 2'b00, 1, 6'd33, 1, 6'd33, 32'h1234);
        expect_val(2, 1, "issue_r33");
        expect_val(1, 64'h1234, "rd33_bypass");
        tick(); drive(1, 2'b00, 1, 6'd33, 0, 6'd0, 0);
        expect_val(3, 64'h2_0000_0000, "set_wins_r33");
        expect_val(2, 0, "waw_stall");
        expect_val(1, 64'h1234, "rd33_stored");
        tick(); drive(1, 2'b00, 1, 6'd5, 0, 6'd0, 0);
        expect_val(4, 3, "stall_cnt_3");
        expect_val(2, 1, "issue_r5_again");
        tick(); flush = 1'b1; drive(1, 2'b00, 1, 6'd7, 1, 6'd7, 32'h77);
        expect_val(3, 64'h2_0000_0020, "busy_r5_r33");
        expect_val(2, 0, "flush_ready");
        tick(); flush = 1'b0; rd_id = {6'd33, 6'd7}; drive(1, 2'b00, 1, 6'd9, 0, 6'd0, 0);
        expect_val(3, 0, "flush_clears");
        expect_val(4, 3, "flush_no_count");
        expect_val(0, 64'h77, "flush_write");
        expect_val(1, 64'h1234, "flush_data_kept");
        expect_val(2, 1, "issue_r9");
        tick(); rst = 1'b1; drive(0, 2'b00, 0, 6'd0, 0, 6'd0, 0);
        expect_val(3, 64'h200, "busy_r9");
        tick(); rst = 1'b0; rd_id = {6'd29, 6'd7}; drive(0, 2'b00, 0, 6'd0, 1, 6'd9, 32'h99);
        expect_val(3, 0, "reset_drops_busy");
        expect_val(0, 0, "reset_clears_data");
        expect_val(1, 64'h30, "reset_sp");
        expect_val(4, 0, "reset_stall");
        tick(); rd_id = {6'd29, 6'd9}; drive(1, 2'b00, 1, 6'd9, 0, 6'd0, 0);
        expect_val(3, 0, "late_wb_no_busy");
        expect_val(0, 64'h99, "late_wb_data");
        expect_val(2, 1, "issue_r9_again");
        tick(); dut.r_stall = 32'hFFFF_FFFE;
        expect_val(4, 64'hFFFF_FFFE, "stall_preset");
        expect_val(2, 0, "waw_r9");
        tick();
        expect_val(4, 64'hFFFF_FFFF, "stall_max");
        tick();
        expect_val(4, 64'hFFFF_FFFF, "stall_sat_1");
        tick(); drive(0, 2'b00, 0, 6'd0, 0, 6'd0, 0);
        expect_val(4, 64'hFFFF_FFFF, "stall_sat_2");
        tick(); tick();
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
